hamming_decoder: RTL and testbench

HAMMING_DECODER -- requirements
Module: hamming_decoder

---
 rtl/hamming_decoder.sv | 149 ++++++++++++++
 tb/tb_hamming_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_decoder.sv
// SECDED Hamming(16,11) block decoder: reads NUM_WORDS codewords from byte memory,
// corrects single errors, flags double errors and writes decoded words back.
module hamming_decoder #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic       mem_we,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] single_cnt,
    output logic [3:0] double_cnt
);

    localparam logic [7:0] SRC  = 8'(SRC_BASE);
    localparam logic [7:0] DST  = 8'(DST_BASE);
    localparam logic [6:0] LAST = 7'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE, RD_LO, RD_HI, CAPT, DEC, WR_LO, WR_HI, FIN
    } state_t;

    state_t      state_q;
    logic [6:0]  idx_q;
    logic [7:0]  lo_q, hi_q;
    logic [10:0] data_q;
    logic [1:0]  flags_q;
    logic [7:0]  addr_q, wdata_q;
    logic        we_q, done_q;
    logic [3:0]  scnt_q, dcnt_q;

    logic [15:0] cw, cw_fix;
    logic [3:0]  syn;
    logic        par;
    logic [10:0] data_d;
    logic [1:0]  flags_d;
    logic [6:0]  idx_nxt;
    logic [7:0]  src_lo, src_nxt, dst_lo;

    always_comb begin
        cw      = {hi_q, lo_q};
        syn     = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (cw[k]) syn = syn ^ 4'(k);
        end
        par     = ^cw;
        cw_fix  = cw;
        // Odd overall parity means exactly one flipped bit; syndrome 0 points at p0.
        if (par) cw_fix[syn] = ~cw[syn];
        data_d  = {cw_fix[15:9], cw_fix[7:5], cw_fix[3]};
        flags_d = '0;
        if (par)             flags_d = 2'b01;
        else if (syn != '0)  flags_d = 2'b10;
    end

    always_comb begin
        idx_nxt = idx_q + 7'd1;
        src_lo  = SRC + {idx_q, 1'b0};
        src_nxt = SRC + {idx_nxt, 1'b0};
        dst_lo  = DST + {idx_q, 1'b0};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            data_q  <= '0;
            flags_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            scnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    if (start) begin
                        state_q <= RD_LO;
                        idx_q   <= '0;
                        scnt_q  <= '0;
                        dcnt_q  <= '0;
                        done_q  <= 1'b0;
                        addr_q  <= SRC;
                        wdata_q <= '0;
                        we_q    <= 1'b0;
                    end
                end
                RD_LO: begin
                    addr_q  <= src_lo + 8'd1;
                    state_q <= RD_HI;
                end
                RD_HI: begin
                    lo_q    <= mem_rdata;
                    state_q <= CAPT;
                end
                CAPT: begin
                    hi_q    <= mem_rdata;
                    state_q <= DEC;
                end
                DEC: begin
                    data_q  <= data_d;
                    flags_q <= flags_d;
                    if (flags_d[0] && scnt_q != 4'hF) scnt_q <= scnt_q + 4'd1;
                    if (flags_d[1] && dcnt_q != 4'hF) dcnt_q <= dcnt_q + 4'd1;
                    addr_q  <= dst_lo;
                    wdata_q <= data_d[7:0];
                    we_q    <= 1'b1;
                    state_q <= WR_LO;
                end
                WR_LO: begin
                    addr_q  <= dst_lo + 8'd1;
                    wdata_q <= {flags_q, 3'b000, data_q[10:8]};
                    state_q <= WR_HI;
                end
                WR_HI: begin
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    if (idx_q == LAST) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                    end else begin
                        idx_q   <= idx_nxt;
                        addr_q  <= src_nxt;
                        state_q <= RD_LO;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Write enable is gated by Reset so an aborting edge never commits a write.
    assign mem_we     = we_q && !Reset;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign done       = done_q;
    assign single_cnt = scnt_q;
    assign double_cnt = dcnt_q;

endmodule

// File: tb/tb_hamming_decoder.sv
// Bench for hamming_decoder: byte memory model, expected-write scoreboard and
// directed codeword vectors covering clean, single-error and double-error words.
module tb_hamming_decoder;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;
    logic [3:0] single_cnt;
    logic [3:0] double_cnt;

    hamming_decoder #(.NUM_WORDS(15), .SRC_BASE(30), .DST_BASE(0)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .single_cnt(single_cnt),
        .double_cnt(double_cnt)
    );

    always #5 Clk = ~Clk;

    logic [7:0] mem [256];
    logic       ld_en = 1'b0;
    logic [7:0] ld_addr = '0;
    logic [7:0] ld_data = '0;

    always @(posedge Clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we)     mem[mem_addr] <= mem_wdata;
        else if (ld_en) mem[ld_addr]  <= ld_data;
    end

    // Hand-derived vectors: codeword and the two bytes it must decode to.
    logic [15:0] cw_t [15] = '{16'h0000, 16'h0008, 16'hFFFE, 16'h0003, 16'hFFFF,
                               16'h000F, 16'h8117, 16'h0033, 16'h0117, 16'h0032,
                               16'h0207, 16'h3FFF, 16'h0010, 16'hFFBF, 16'h8000};
    logic [7:0]  lo_t [15] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF,
                               8'h01, 8'h00, 8'h02, 8'h00, 8'h02,
                               8'h10, 8'hFF, 8'h00, 8'hFF, 8'h00};
    logic [7:0]  hi_t [15] = '{8'h00, 8'h40, 8'h47, 8'h80, 8'h07,
                               8'h00, 8'h04, 8'h00, 8'h44, 8'h40,
                               8'h80, 8'h81, 8'h40, 8'h47, 8'h40};

    logic [15:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int lat;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge Clk);
        ld_en   = 1'b0;
    endtask

    // mode 0: vector table; mode 1: every word is 16'h0008 (single error at d1)
    task automatic load_words(input int mode);
        logic [15:0] c;
        for (int w = 0; w < 15; w++) begin
            c = (mode == 0) ? cw_t[w] : 16'h0008;
            load_byte(8'(30 + 2 * w), c[7:0]);
            load_byte(8'(31 + 2 * w), c[15:8]);
        end
    endtask

    task automatic push_words(input int nw, input int mode);
        logic [7:0] lo, hi;
        for (int w = 0; w < nw; w++) begin
            lo = (mode == 0) ? lo_t[w] : 8'h00;
            hi = (mode == 0) ? hi_t[w] : 8'h40;
            exp_q.push_back({8'(2 * w), lo});
            exp_q.push_back({8'(2 * w + 1), hi});
        end
    endtask

    task automatic kick();
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
    endtask

    // lat counts edges with the start-sampling edge as 1.
    task automatic wait_done(input int pa, input int pb, output int l);
        l = 1;
        while (done !== 1'b1 && l < 200) begin
            start = (l == pa || l == pb);
            @(negedge Clk);
            l++;
        end
        start = 1'b0;
    endtask

    task automatic monitor();
        logic [15:0] e;
        forever begin
            @(negedge Clk);
            if (mem_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
                    chk("wr_data", {24'd0, mem_wdata}, {24'd0, e[7:0]});
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
        join_none

        repeat (3) @(negedge Clk);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_we", {31'd0, mem_we}, 0);
        chk("rst_addr", {24'd0, mem_addr}, 0);
        chk("rst_wdata", {24'd0, mem_wdata}, 0);
        chk("rst_single", {28'd0, single_cnt}, 0);
        chk("rst_double", {28'd0, double_cnt}, 0);
        Reset = 1'b0;

        load_words(0);
        push_words(15, 0);
        kick();
        wait_done(-1, -1, lat);
        chk("run1_latency", lat, 91);
        chk("run1_single", {28'd0, single_cnt}, 7);
        chk("run1_double", {28'd0, double_cnt}, 3);
        chk("run1_queue_empty", exp_q.size(), 0);
        chk("run1_mem0", {24'd0, mem[0]}, 8'h00);
        chk("run1_mem1", {24'd0, mem[1]}, 8'h00);
        chk("run1_mem3", {24'd0, mem[3]}, 8'h40);
        chk("run1_mem4", {24'd0, mem[4]}, 8'hFF);
        chk("run1_mem5", {24'd0, mem[5]}, 8'h47);
        chk("run1_mem7", {24'd0, mem[7]}, 8'h80);
        repeat (3) @(negedge Clk);
        chk("fin_done_held", {31'd0, done}, 1);
        chk("fin_addr", {24'd0, mem_addr}, 0);
        chk("fin_wdata", {24'd0, mem_wdata}, 0);
        chk("fin_we", {31'd0, mem_we}, 0);

        push_words(15, 0);
        kick();
        wait_done(10, 47, lat);
        chk("run2_latency", lat, 91);
        chk("run2_single", {28'd0, single_cnt}, 7);
        chk("run2_double", {28'd0, double_cnt}, 3);
        chk("run2_queue_empty", exp_q.size(), 0);

        load_words(1);
        push_words(15, 1);
        kick();
        wait_done(-1, -1, lat);
        chk("run3_latency", lat, 91);
        chk("run3_single_max", {28'd0, single_cnt}, 15);
        chk("run3_double_clr", {28'd0, double_cnt}, 0);
        chk("run3_queue_empty", exp_q.size(), 0);

        load_words(0);
        for (int a = 0; a < 30; a++) load_byte(8'(a), 8'hAA);
        push_words(3, 0);
        kick();
        repeat (21) @(negedge Clk);
        @(posedge Clk);
        #1 Reset = 1'b1;
        #1 chk("abort_we_gated", {31'd0, mem_we}, 0);
        @(posedge Clk);
        #1;
        chk("abort_done", {31'd0, done}, 0);
        chk("abort_we", {31'd0, mem_we}, 0);
        chk("abort_addr", {24'd0, mem_addr}, 0);
        chk("abort_wdata", {24'd0, mem_wdata}, 0);
        chk("abort_single", {28'd0, single_cnt}, 0);
        chk("abort_double", {28'd0, double_cnt}, 0);
        Reset = 1'b0;
        repeat (20) @(negedge Clk);
        chk("abort_queue_empty", exp_q.size(), 0);
        chk("abort_mem4", {24'd0, mem[4]}, 8'hFF);
        chk("abort_mem5", {24'd0, mem[5]}, 8'h47);
        chk("abort_mem6", {24'd0, mem[6]}, 8'hAA);
        chk("abort_mem7", {24'd0, mem[7]}, 8'hAA);
        chk("abort_idle_done", {31'd0, done}, 0);

        push_words(15, 0);
        kick();
        wait_done(-1, -1, lat);
        chk("run5_latency", lat, 91);
        chk("run5_single", {28'd0, single_cnt}, 7);
        chk("run5_double", {28'd0, double_cnt}, 3);
        chk("run5_queue_empty", exp_q.size(), 0);
        chk("run5_mem6", {24'd0, mem[6]}, 8'h00);
        chk("run5_mem7", {24'd0, mem[7]}, 8'h80);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
